// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_seq
// Converts packed BCD to binary, one digit per cycle, most significant first.
// Define BCD_DIGIT_CHECK_EN to flag (and zero) results with digits above 9.
// Revision : 1.0
// ============================================================================
module bcd_to_bin_seq #(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW-1:0]     bin_out,
  output logic              err,
  output logic              busy
);

  localparam int c_cw = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [4*NDIG-1:0] r_sr;
  logic [BW-1:0]     r_acc;
  logic [BW-1:0]     r_result;
  logic [BW-1:0]     w_acc_next;
  logic [c_cw-1:0]   r_cnt;
  logic [3:0]        w_digit;
  logic              w_accept;
  logic              w_last;
  logic              w_bad_result;

  assign w_digit    = r_sr[4*NDIG-1 -: 4];
  // acc*10 built from two shifts so no multiplier is inferred
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BW'(w_digit);
  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_last     = (r_state == CONV) && (r_cnt == c_last);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign bin_out   = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = CONV;
      CONV:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_sr  <= bcd_in;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == CONV) begin
      r_acc <= w_acc_next;
      r_sr  <= r_sr << 4;
      r_cnt <= r_cnt + c_cw'(1);
      if (w_last) begin
        r_result <= w_bad_result ? '0 : w_acc_next;
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic r_dig_err;
  logic r_err;

  // sticky across the request, including the digit being processed now
  assign w_bad_result = r_dig_err || (w_digit > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig_err <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_dig_err <= 1'b0;
    end else if (r_state == CONV) begin
      r_dig_err <= w_bad_result;
      if (w_last) begin
        r_err <= w_bad_result;
      end
    end
  end

  assign err = r_err;
`else
  assign w_bad_result = 1'b0;
  assign err          = 1'b0;
`endif

endmodule
`default_nettype wire
